// File: rtl/boss_hp_pkg.sv
// Shared boss constants: health and phase thresholds, hitbox sizes, FSM encoding.
package boss_hp_pkg;

    localparam logic [9:0] HP_MAX    = 10'd450;
    localparam logic [9:0] HP_PHASE2 = 10'd300;
    localparam logic [9:0] HP_PHASE3 = 10'd150;
    localparam logic [9:0] HIT_DMG   = 10'd10;

    localparam int unsigned BOSS_W = 64;
    localparam int unsigned BOSS_H = 48;
    localparam int unsigned BUL_W  = 4;
    localparam int unsigned BUL_H  = 8;

    localparam int unsigned IFRAME_TICKS = 8;
    localparam int unsigned IFRAME_W     = $clog2(IFRAME_TICKS);
    localparam int unsigned REGEN_TICKS  = 32;
    localparam int unsigned REGEN_W      = $clog2(REGEN_TICKS);

    typedef enum logic [1:0] {
        StWait   = 2'd0,
        StFight  = 2'd1,
        StIframe = 2'd2,
        StDead   = 2'd3
    } boss_state_e;

    // Highest health allowed in the phase that hp currently sits in.
    function automatic logic [9:0] phase_ceiling(input logic [9:0] hp);
        if (hp <= HP_PHASE3) begin
            return HP_PHASE3;
        end else if (hp <= HP_PHASE2) begin
            return HP_PHASE2;
        end else begin
            return HP_MAX;
        end
    endfunction

endpackage

// File: rtl/boss_hit_box.sv
// Combinational AABB overlap between one bullet and the boss hitbox.
// All edges are formed 11 bits wide so hitboxes near x/y=1023 do not wrap.
module boss_hit_box
    import boss_hp_pkg::*;
(
    input  logic       i_bul_v,
    input  logic [9:0] i_bul_x,
    input  logic [9:0] i_bul_y,
    input  logic [9:0] i_boss_x,
    input  logic [9:0] i_boss_y,
    output logic       o_hit
);

    logic [10:0] w_bul_l;
    logic [10:0] w_bul_r;
    logic [10:0] w_bul_t;
    logic [10:0] w_bul_b;
    logic [10:0] w_boss_l;
    logic [10:0] w_boss_r;
    logic [10:0] w_boss_t;
    logic [10:0] w_boss_b;

    assign w_bul_l  = {1'b0, i_bul_x};
    assign w_bul_r  = {1'b0, i_bul_x} + 11'(BUL_W);
    assign w_bul_t  = {1'b0, i_bul_y};
    assign w_bul_b  = {1'b0, i_bul_y} + 11'(BUL_H);
    assign w_boss_l = {1'b0, i_boss_x};
    assign w_boss_r = {1'b0, i_boss_x} + 11'(BOSS_W);
    assign w_boss_t = {1'b0, i_boss_y};
    assign w_boss_b = {1'b0, i_boss_y} + 11'(BOSS_H);

    assign o_hit = i_bul_v
                 & (w_bul_r > w_boss_l) & (w_bul_l < w_boss_r)
                 & (w_bul_b > w_boss_t) & (w_bul_t < w_boss_b);

endmodule

// File: rtl/boss_hp.sv
// Boss health: bullet overlap, damage with invulnerability window, hit pulses, death flag.
// Optional idle regeneration below the current phase ceiling: define BOSS_HP_REGEN_EN.
module boss_hp
    import boss_hp_pkg::*;
(
    input  logic       clk22,
    input  logic       rst,
    input  logic       boss,
    input  logic [9:0] bossx,
    input  logic [9:0] bossy,
    input  logic       b1_v,
    input  logic [9:0] b1x,
    input  logic [9:0] b1y,
    input  logic       b2_v,
    input  logic [9:0] b2x,
    input  logic [9:0] b2y,
    output logic [9:0] bosshp,
    output logic       b1_hit,
    output logic       b2_hit,
    output logic       boss_dead
);

    boss_state_e         r_state;
    boss_state_e         w_state_d;
    logic [9:0]          r_hp;
    logic [9:0]          w_hp_d;
    logic [IFRAME_W-1:0] r_ifr;
    logic [IFRAME_W-1:0] w_ifr_d;
    logic                r_b1_hit;
    logic                w_b1_hit_d;
    logic                r_b2_hit;
    logic                w_b2_hit_d;
    logic                w_ov1;
    logic                w_ov2;
    logic [9:0]          w_dmg;
`ifdef BOSS_HP_REGEN_EN
    logic [REGEN_W-1:0]  r_idle;
    logic [REGEN_W-1:0]  w_idle_d;
`endif

    boss_hit_box u_hit_b1 (
        .i_bul_v  (b1_v),
        .i_bul_x  (b1x),
        .i_bul_y  (b1y),
        .i_boss_x (bossx),
        .i_boss_y (bossy),
        .o_hit    (w_ov1)
    );

    boss_hit_box u_hit_b2 (
        .i_bul_v  (b2_v),
        .i_bul_x  (b2x),
        .i_bul_y  (b2y),
        .i_boss_x (bossx),
        .i_boss_y (bossy),
        .o_hit    (w_ov2)
    );

    assign w_dmg = (w_ov1 ? HIT_DMG : 10'd0) + (w_ov2 ? HIT_DMG : 10'd0);

    // Next state, health, iframe counter and hit pulses.
    always_comb begin
        w_state_d  = r_state;
        w_hp_d     = r_hp;
        w_ifr_d    = r_ifr;
        w_b1_hit_d = 1'b0;
        w_b2_hit_d = 1'b0;
`ifdef BOSS_HP_REGEN_EN
        w_idle_d   = '0;
`endif
        unique case (r_state)
            StWait: begin
                if (boss && (r_hp != 10'd0)) begin
                    w_state_d = StFight;
                end
            end
            StFight: begin
                // Losing the boss wins over any same-tick overlap.
                if (!boss) begin
                    w_state_d = StWait;
                    w_ifr_d   = '0;
                end else begin
                    w_b1_hit_d = w_ov1;
                    w_b2_hit_d = w_ov2;
                    if (w_dmg != 10'd0) begin
                        if (r_hp <= w_dmg) begin
                            w_hp_d    = 10'd0;
                            w_state_d = StDead;
                        end else begin
                            w_hp_d    = r_hp - w_dmg;
                            w_ifr_d   = IFRAME_W'(IFRAME_TICKS - 1);
                            w_state_d = StIframe;
                        end
                    end else begin
`ifdef BOSS_HP_REGEN_EN
                        if (r_idle == REGEN_W'(REGEN_TICKS - 1)) begin
                            w_idle_d = '0;
                            if (r_hp < phase_ceiling(r_hp)) begin
                                w_hp_d = r_hp + 10'd1;
                            end
                        end else begin
                            w_idle_d = r_idle + 1'b1;
                        end
`else
                        // No overlap: health is held.
                        w_hp_d = r_hp;
`endif
                    end
                end
            end
            StIframe: begin
                if (!boss) begin
                    w_state_d = StWait;
                    w_ifr_d   = '0;
                end else begin
                    // Bullets are still absorbed, just without damage.
                    w_b1_hit_d = w_ov1;
                    w_b2_hit_d = w_ov2;
                    if (r_ifr == '0) begin
                        w_state_d = StFight;
                    end else begin
                        w_ifr_d = r_ifr - 1'b1;
                    end
                end
            end
            StDead: begin
                w_hp_d = 10'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk22) begin
        if (rst) begin
            r_state  <= StWait;
            r_hp     <= HP_MAX;
            r_ifr    <= '0;
            r_b1_hit <= 1'b0;
            r_b2_hit <= 1'b0;
`ifdef BOSS_HP_REGEN_EN
            r_idle   <= '0;
`endif
        end else begin
            r_state  <= w_state_d;
            r_hp     <= w_hp_d;
            r_ifr    <= w_ifr_d;
            r_b1_hit <= w_b1_hit_d;
            r_b2_hit <= w_b2_hit_d;
`ifdef BOSS_HP_REGEN_EN
            r_idle   <= w_idle_d;
`endif
        end
    end

    assign bosshp    = r_hp;
    assign b1_hit    = r_b1_hit;
    assign b2_hit    = r_b2_hit;
    assign boss_dead = (r_state == StDead);

endmodule
